// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } dmem_state_e;

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: byte-enabled synchronous write, registered synchronous read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  input  logic              we,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  input  logic              re,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Contents and read register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: request handshake, programmable wait states, access, response handshake.
// Optional misaligned-access error response enabled by DMEM_MISALIGN_ERR_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W    = idx_w(DEPTH);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  dmem_state_e state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic [IDX_W-1:0]  req_idx;
  logic              accept;
  logic              misalign;
  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_idx;
  logic [WORD_W-1:0] arr_rdata;
  logic              unused_addr;

  assign req_idx     = req_addr[IDX_W+1:2];
  assign accept      = (state_q == StIdle) && req_valid;
  assign unused_addr = ^{req_addr[WORD_W-1:IDX_W+2], req_addr[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
  logic [1:0] off_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_q <= 2'b00;
    end else if (accept) begin
      off_q <= req_addr[1:0];
    end
  end

  assign misalign = (off_q != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      idx_q   <= req_idx;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = (WAIT_CYCLES == 0) ? StAccess : StWait;
          cnt_d   = WaitInit;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: begin
        state_d     = StResp;
        rsp_err_d   = misalign;
        rsp_rdata_d = (we_q || misalign) ? '0 : arr_rdata;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The array read is launched one cycle ahead so its registered output is ready in ACCESS.
  assign arr_re  = ((state_q == StIdle) && req_valid && !req_we && (WAIT_CYCLES == 0)) ||
                   ((state_q == StWait) && (cnt_q == 4'd1) && !we_q);
  assign arr_we  = (state_q == StAccess) && we_q && !misalign;
  assign arr_idx = (state_q == StIdle) ? req_idx : idx_q;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .idx   (arr_idx),
    .we    (arr_we),
    .wdata (wdata_q),
    .be    (be_q),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
